// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_pkg: shared constants for the VGA raster timing generator.
//   vga_mode_t   - one complete video mode (active/porch/sync sizes and
//                  sync polarities for both axes)
//   MODE_*       - standard 60 Hz modes: 640x480, 800x600, 1024x768
//   calc_cnt_w() - counter width needed to hold (total - 1)
package vga_timing_pkg;

  typedef struct packed {
    int   h_active;
    int   h_fp;
    int   h_sync;
    int   h_bp;
    int   v_active;
    int   v_fp;
    int   v_sync;
    int   v_bp;
    logic hs_pol;
    logic vs_pol;
  } vga_mode_t;

  localparam vga_mode_t MODE_640X480 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    hs_pol: 1'b0, vs_pol: 1'b0};

  localparam vga_mode_t MODE_800X600 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    hs_pol: 1'b1, vs_pol: 1'b1};

  localparam vga_mode_t MODE_1024X768 = '{
    h_active: 1024, h_fp: 24, h_sync: 136, h_bp: 160,
    v_active: 768,  v_fp: 3,  v_sync: 6,   v_bp: 29,
    hs_pol: 1'b0, vs_pol: 1'b0};

  // A counter of $clog2(total) bits holds total-1; a width of at least one
  // bit is kept for degenerate single-position axes.
  function automatic int calc_cnt_w(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: bundle between the timing generator and the video
// pipeline stages that consume its raster position.
//   en                  - pixel advance enable (consumer -> generator)
//   hcount/vcount       - raster position
//   hsync/vsync         - sync levels (polarity set by the generator)
//   hblnk/vblnk/de      - blanking and data-enable levels
//   line_start          - one-clock strobe at the first pixel of a line
//   frame_start         - one-clock strobe at the first pixel of a frame
//   frame_cnt           - frame number, only with VGA_TIMING_FRAME_CNT_EN
// Modports: master = generator side, slave = consumer side.
interface vga_timing_gen_if #(
  parameter int CNT_W = 11
`ifdef VGA_TIMING_FRAME_CNT_EN
  , parameter int FCNT_W = 8
`endif
);

  logic             en;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hsync;
  logic             vsync;
  logic             hblnk;
  logic             vblnk;
  logic             de;
  logic             line_start;
  logic             frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FCNT_W-1:0] frame_cnt;

  modport master (input en, output hcount, vcount, hsync, vsync, hblnk, vblnk,
                  de, line_start, frame_start, frame_cnt);
  modport slave  (output en, input hcount, vcount, hsync, vsync, hblnk, vblnk,
                  de, line_start, frame_start, frame_cnt);
`else
  modport master (input en, output hcount, vcount, hsync, vsync, hblnk, vblnk,
                  de, line_start, frame_start);
  modport slave  (output en, input hcount, vcount, hsync, vsync, hblnk, vblnk,
                  de, line_start, frame_start);
`endif

endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
//   clk, rst_n  - clock, asynchronous active-low reset
//   step        - advance the position by one on this edge
//   count       - registered position, 0..TOTAL-1
//   sync        - registered sync level (POL while inside the sync window)
//   blank       - registered blank level (count >= ACTIVE)
//   blank_next  - value blank takes on the coming edge (for derived flops)
//   wrap        - current position is the last one (or out of range), so
//                 the next step returns to 0
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   CNT_W  = 11,
  parameter int   ACTIVE = 800,
  parameter int   FP     = 40,
  parameter int   SYNC   = 128,
  parameter int   BP     = 88,
  parameter logic POL    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  output logic [CNT_W-1:0] count,
  output logic             sync,
  output logic             blank,
  output logic             blank_next,
  output logic             wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] count_q, count_d;
  logic             sync_q, sync_d;
  logic             blank_q, blank_d;

  // Using >= rather than == means a corrupted count beyond the last
  // position still returns to 0 on the next step instead of running on.
  assign wrap = (count_q >= LAST);

  // Next position plus the levels decoded from it, so sync and blank land
  // in the same cycle as the count they describe. Without a step all hold.
  always_comb begin
    count_d = count_q;
    sync_d  = sync_q;
    blank_d = blank_q;
    if (step) begin
      count_d = wrap ? '0 : count_q + CNT_W'(1);
      blank_d = (count_d >= ACT_END);
      sync_d  = ((count_d >= SYNC_START) && (count_d < SYNC_END)) ? POL : ~POL;
    end
  end

  // Axis state registers; reset puts the axis at position 0 with sync
  // inactive and blank low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      sync_q  <= ~POL;
      blank_q <= 1'b0;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
      blank_q <= blank_d;
    end
  end

  assign count      = count_q;
  assign sync       = sync_q;
  assign blank      = blank_q;
  assign blank_next = blank_d;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
//   clk    - pixel-domain clock
//   rst_n  - asynchronous active-low reset
//   vid    - vga_timing_gen_if.master: en in; hcount, vcount, hsync, vsync,
//            hblnk, vblnk, de, line_start, frame_start (and frame_cnt) out
// All outputs are registered and mutually aligned. The mode defaults to
// 800x600@60; other modes come from the MODE_* sets in vga_timing_pkg.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add the frame_cnt
// output, which increments with every frame_start and wraps at 2^FCNT_W.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CNT_W    = 11,
  parameter int   H_ACTIVE = MODE_800X600.h_active,
  parameter int   H_FP     = MODE_800X600.h_fp,
  parameter int   H_SYNC   = MODE_800X600.h_sync,
  parameter int   H_BP     = MODE_800X600.h_bp,
  parameter int   V_ACTIVE = MODE_800X600.v_active,
  parameter int   V_FP     = MODE_800X600.v_fp,
  parameter int   V_SYNC   = MODE_800X600.v_sync,
  parameter int   V_BP     = MODE_800X600.v_bp,
  parameter logic HS_POL   = MODE_800X600.hs_pol,
  parameter logic VS_POL   = MODE_800X600.vs_pol,
  parameter int   FCNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_timing_gen_if.master   vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((H_ACTIVE < 1) || (H_FP < 1) || (H_SYNC < 1) || (H_BP < 1) ||
      (V_ACTIVE < 1) || (V_FP < 1) || (V_SYNC < 1) || (V_BP < 1)) begin : g_bad_sizes
    $fatal(1, "vga_timing_gen: every active/porch/sync size must be >= 1");
  end
  if ((CNT_W < calc_cnt_w(H_TOTAL)) || (CNT_W < calc_cnt_w(V_TOTAL))) begin : g_bad_cnt_w
    $fatal(1, "vga_timing_gen: CNT_W cannot hold H_TOTAL-1 / V_TOTAL-1");
  end
  if (FCNT_W < 1) begin : g_bad_fcnt_w
    $fatal(1, "vga_timing_gen: FCNT_W must be >= 1");
  end

  logic h_wrap, v_wrap;
  logic h_blank_next, v_blank_next;
  logic v_step;

  // The vertical axis advances only on the step that ends a line.
  assign v_step = vid.en & h_wrap;

  vga_axis_counter #(
    .CNT_W(CNT_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
  ) u_h_axis (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (vid.en),
    .count      (vid.hcount),
    .sync       (vid.hsync),
    .blank      (vid.hblnk),
    .blank_next (h_blank_next),
    .wrap       (h_wrap)
  );

  vga_axis_counter #(
    .CNT_W(CNT_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
  ) u_v_axis (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (v_step),
    .count      (vid.vcount),
    .sync       (vid.vsync),
    .blank      (vid.vblnk),
    .blank_next (v_blank_next),
    .wrap       (v_wrap)
  );

  logic de_q, de_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  // Strobes fire only for an enabled step that lands on hcount 0 (and
  // vcount 0 for a frame); an idle cycle clears them. de is decoded from
  // the next blank values so it stays aligned with the counters.
  always_comb begin
    line_start_d  = vid.en & h_wrap;
    frame_start_d = line_start_d & v_wrap;
    de_d          = ~(h_blank_next | v_blank_next);
  end

  // Strobe and data-enable registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vid.de          = de_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // Frame number moves in the same edge that raises frame_start and wraps
  // naturally at the register width.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) frame_cnt_d = frame_cnt_q + FCNT_W'(1);
  end

  // Frame counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign vid.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: self-checking bench for vga_timing_gen. Three instances
// run side by side from one enable: the default 800x600 mode, 640x480 with
// negative syncs, and a tiny mode (8x6 total) that makes frame wrap and
// vertical sync reachable in a few hundred clocks. Expected values come
// from a position model (enabled-step count -> raster position -> levels)
// and from hand-written vectors for the tiny mode.
// Honours VGA_TIMING_FRAME_CNT_EN when it is defined.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  // Tiny mode: H = 4+1+2+1 = 8, V = 3+1+1+1 = 6, hsync high, vsync low.
  localparam vga_mode_t SMALL = '{
    h_active: 4, h_fp: 1, h_sync: 2, h_bp: 1,
    v_active: 3, v_fp: 1, v_sync: 1, v_bp: 1,
    hs_pol: 1'b1, vs_pol: 1'b0};

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, vs, hb, vb, de, ls, fs;
    logic [7:0]  fc;
  } obs_t;

  typedef struct {
    logic en;
    obs_t exp;
  } vec_t;

  logic clk;
  logic rst_n;
  logic en;
  int   n;       // enabled steps since the last reset
  bit   le;      // enable seen at the most recent edge
  int   errors;
  int   checks;

  vga_timing_gen_if #(.CNT_W(11)) def_if ();
  vga_timing_gen_if #(.CNT_W(11)) vga_if ();
`ifdef VGA_TIMING_FRAME_CNT_EN
  vga_timing_gen_if #(.CNT_W(11), .FCNT_W(2)) sm_if ();
`else
  vga_timing_gen_if #(.CNT_W(11)) sm_if ();
`endif

  assign def_if.en = en;
  assign vga_if.en = en;
  assign sm_if.en  = en;

  vga_timing_gen u_def (.clk(clk), .rst_n(rst_n), .vid(def_if));

  vga_timing_gen #(
    .CNT_W(11),
    .H_ACTIVE(MODE_640X480.h_active), .H_FP(MODE_640X480.h_fp),
    .H_SYNC(MODE_640X480.h_sync), .H_BP(MODE_640X480.h_bp),
    .V_ACTIVE(MODE_640X480.v_active), .V_FP(MODE_640X480.v_fp),
    .V_SYNC(MODE_640X480.v_sync), .V_BP(MODE_640X480.v_bp),
    .HS_POL(MODE_640X480.hs_pol), .VS_POL(MODE_640X480.vs_pol),
    .FCNT_W(8)
  ) u_vga (.clk(clk), .rst_n(rst_n), .vid(vga_if));

  vga_timing_gen #(
    .CNT_W(11),
    .H_ACTIVE(SMALL.h_active), .H_FP(SMALL.h_fp), .H_SYNC(SMALL.h_sync), .H_BP(SMALL.h_bp),
    .V_ACTIVE(SMALL.v_active), .V_FP(SMALL.v_fp), .V_SYNC(SMALL.v_sync), .V_BP(SMALL.v_bp),
    .HS_POL(SMALL.hs_pol), .VS_POL(SMALL.vs_pol),
    .FCNT_W(2)
  ) u_sm (.clk(clk), .rst_n(rst_n), .vid(sm_if));

  obs_t def_obs, vga_obs, sm_obs;

  assign def_obs.h  = def_if.hcount;
  assign def_obs.v  = def_if.vcount;
  assign def_obs.hs = def_if.hsync;
  assign def_obs.vs = def_if.vsync;
  assign def_obs.hb = def_if.hblnk;
  assign def_obs.vb = def_if.vblnk;
  assign def_obs.de = def_if.de;
  assign def_obs.ls = def_if.line_start;
  assign def_obs.fs = def_if.frame_start;

  assign vga_obs.h  = vga_if.hcount;
  assign vga_obs.v  = vga_if.vcount;
  assign vga_obs.hs = vga_if.hsync;
  assign vga_obs.vs = vga_if.vsync;
  assign vga_obs.hb = vga_if.hblnk;
  assign vga_obs.vb = vga_if.vblnk;
  assign vga_obs.de = vga_if.de;
  assign vga_obs.ls = vga_if.line_start;
  assign vga_obs.fs = vga_if.frame_start;

  assign sm_obs.h  = sm_if.hcount;
  assign sm_obs.v  = sm_if.vcount;
  assign sm_obs.hs = sm_if.hsync;
  assign sm_obs.vs = sm_if.vsync;
  assign sm_obs.hb = sm_if.hblnk;
  assign sm_obs.vb = sm_if.vblnk;
  assign sm_obs.de = sm_if.de;
  assign sm_obs.ls = sm_if.line_start;
  assign sm_obs.fs = sm_if.frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
  assign def_obs.fc = def_if.frame_cnt;
  assign vga_obs.fc = vga_if.frame_cnt;
  assign sm_obs.fc  = 8'(sm_if.frame_cnt);
`else
  assign def_obs.fc = '0;
  assign vga_obs.fc = '0;
  assign sm_obs.fc  = '0;
`endif

  // Pixel clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after n enabled steps from reset, with le telling
  // whether the latest edge was an enabled one.
  function automatic obs_t model(input vga_mode_t m, input int steps, input bit last_en,
                                 input int fcw);
    obs_t o;
    int ht, vt, h, v;
    ht = m.h_active + m.h_fp + m.h_sync + m.h_bp;
    vt = m.v_active + m.v_fp + m.v_sync + m.v_bp;
    h  = steps % ht;
    v  = (steps / ht) % vt;
    o.h  = 11'(h);
    o.v  = 11'(v);
    o.hs = ((h >= m.h_active + m.h_fp) && (h < m.h_active + m.h_fp + m.h_sync)) ?
           m.hs_pol : ~m.hs_pol;
    o.vs = ((v >= m.v_active + m.v_fp) && (v < m.v_active + m.v_fp + m.v_sync)) ?
           m.vs_pol : ~m.vs_pol;
    o.hb = (h >= m.h_active);
    o.vb = (v >= m.v_active);
    o.de = ~o.hb & ~o.vb;
    o.ls = last_en && (h == 0);
    o.fs = o.ls && (v == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    o.fc = 8'((steps / (ht * vt)) % (1 << fcw));
`else
    o.fc = '0;
    if (fcw < 0) o.fc = '1;
`endif
    return o;
  endfunction

  function automatic obs_t mk(input int h, input int v, input logic hs, input logic vs,
                              input logic hb, input logic vb, input logic de,
                              input logic ls, input logic fs, input int fc);
    obs_t o;
    o.h = 11'(h); o.v = 11'(v);
    o.hs = hs; o.vs = vs; o.hb = hb; o.vb = vb; o.de = de; o.ls = ls; o.fs = fs;
`ifdef VGA_TIMING_FRAME_CNT_EN
    o.fc = 8'(fc);
`else
    o.fc = (fc < 0) ? '1 : '0;
`endif
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("h=%0d v=%0d hs=%0b vs=%0b hb=%0b vb=%0b de=%0b ls=%0b fs=%0b fc=%0d",
                     o.h, o.v, o.hs, o.vs, o.hb, o.vb, o.de, o.ls, o.fs, o.fc);
  endfunction

  // Drive en at the falling edge, take one rising edge, then return at the
  // next falling edge where outputs are stable.
  task automatic applyStimulus(input logic e);
    en = e;
    @(posedge clk);
    if (e) n++;
    le = e;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (n=%0d): got %s, want %s", name, n, fmt(act), fmt(exp));
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "/800x600"}, def_obs, model(MODE_800X600, n, le, 8));
    checkOutput({tag, "/640x480"}, vga_obs, model(MODE_640X480, n, le, 8));
    checkOutput({tag, "/small"},   sm_obs,  model(SMALL, n, le, 2));
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    en    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n  = 0;
    le = 1'b0;
  endtask

  vec_t tab[12];

  initial begin
    rst_n = 1'b0; en = 1'b0; n = 0; le = 1'b0; errors = 0; checks = 0;

    // Tiny mode, one line and a bit: hsync at 5..6, blank from 4, vsync
    // inactive (high) on lines 0 and 1, strobes only after an enabled wrap.
    tab[0]  = '{1'b1, mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0)};
    tab[1]  = '{1'b0, mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0)};
    tab[2]  = '{1'b1, mk(2, 0, 0, 1, 0, 0, 1, 0, 0, 0)};
    tab[3]  = '{1'b1, mk(3, 0, 0, 1, 0, 0, 1, 0, 0, 0)};
    tab[4]  = '{1'b1, mk(4, 0, 0, 1, 1, 0, 0, 0, 0, 0)};
    tab[5]  = '{1'b1, mk(5, 0, 1, 1, 1, 0, 0, 0, 0, 0)};
    tab[6]  = '{1'b0, mk(5, 0, 1, 1, 1, 0, 0, 0, 0, 0)};
    tab[7]  = '{1'b1, mk(6, 0, 1, 1, 1, 0, 0, 0, 0, 0)};
    tab[8]  = '{1'b1, mk(7, 0, 0, 1, 1, 0, 0, 0, 0, 0)};
    tab[9]  = '{1'b1, mk(0, 1, 0, 1, 0, 0, 1, 1, 0, 0)};
    tab[10] = '{1'b0, mk(0, 1, 0, 1, 0, 0, 1, 0, 0, 0)};
    tab[11] = '{1'b1, mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0)};

    // Reset held for 5 clocks.
    repeat (5) @(negedge clk);
    checkOutput("reset/800x600", def_obs, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    checkOutput("reset/640x480", vga_obs, mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0));
    checkOutput("reset/small",   sm_obs,  mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(tab[i].en);
      checkOutput($sformatf("vec%0d/small", i), sm_obs, tab[i].exp);
    end

    // Hand-written frame wrap on the tiny mode: (7,5) -> (0,0) with both strobes.
    resetDut();
    repeat (47) applyStimulus(1'b1);
    checkOutput("frame_last/small", sm_obs, mk(7, 5, 0, 1, 1, 1, 0, 0, 0, 0));
    applyStimulus(1'b1);
    checkOutput("frame_wrap/small", sm_obs, mk(0, 0, 0, 1, 0, 0, 1, 1, 1, 1));
    applyStimulus(1'b1);
    checkOutput("frame_after/small", sm_obs, mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 1));

    // Continuous run past a full 800x600 line: covers both horizontal
    // decodes of the large modes and many tiny-mode frames.
    resetDut();
    checkAll("post_reset");
    for (int i = 0; i < 1060; i++) begin
      applyStimulus(1'b1);
      checkAll("run");
    end

    // Enable toggling every clock: positions advance every other clock.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(logic'(i % 2));
      checkAll("toggle");
    end

    // Reset pulsed between edges must clear outputs before the next edge.
    en = 1'b1;
    @(posedge clk);
    n++;
    le = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    n  = 0;
    le = 1'b0;
    checkAll("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    checkAll("released");
    applyStimulus(1'b1);
    checkOutput("resume/800x600", def_obs, mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1);
      checkAll("resume");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
